// File: rtl/window3x3_stream.sv
// Streaming 3x3 neighbourhood generator with two line buffers.
// Zero-pad or edge-replicate borders; valid/ready on both sides.
module window3x3_stream #(
  parameter  int CH_W  = 8,
  parameter  int N_CH  = 3,
  parameter  int MAX_W = 480,
  parameter  int MAX_H = 272,
  localparam int PIX_W = N_CH * CH_W,
  localparam int XW    = $clog2(MAX_W + 1),
  localparam int YW    = $clog2(MAX_H + 1)
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [XW-1:0]      iWidth,
  input  logic [YW-1:0]      iHeight,
  input  logic               iBorder,
  input  logic               iValid,
  input  logic               iSof,
  input  logic [PIX_W-1:0]   iPixel,
  output logic               oReady,
  output logic               oValid,
  input  logic               iReady,
  output logic [9*PIX_W-1:0] oWin,
  output logic               oSof,
  output logic               oEol,
  output logic               oCfgErr
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_EOL  = 3'd3;
  localparam logic [2:0] S_LAST = 3'd4;

  logic [2:0]    st_q, st_d;
  logic [XW-1:0] w_q, w_d, x_q, x_d;
  logic [YW-1:0] h_q, h_d, y_q, y_d;
  logic          mode_q, mode_d;
  logic          cfg_q, cfg_d;
  logic          run_q;
  logic          val_q, val_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;
  logic [9*PIX_W-1:0] win_q, win_d;
  // columns hold {top, mid, bottom} rows, index 0 = top
  logic [2:0][PIX_W-1:0] c1_q, c1_d, c2_q, c2_d;

  logic [PIX_W-1:0] lb_a_q [MAX_W];
  logic [PIX_W-1:0] lb_b_q [MAX_W];

  logic          free, acc, sof_acc, size_ok;
  logic          wr, shift, emit, eol_n;
  logic          tv, bv, lv, rv;
  logic [XW-1:0] cx, wx, ri;
  logic [YW-1:0] cy;
  logic [2:0][PIX_W-1:0] ncol;
  logic [2:0][2:0][PIX_W-1:0] raw, fr;
  logic [2:0][2:0][PIX_W-1:0] fc;
  logic [9*PIX_W-1:0] win_n;

  always_comb begin
    free    = !val_q || iReady;
    oReady  = run_q && free &&
              (st_q == S_IDLE || st_q == S_FILL || st_q == S_RUN);
    acc     = iValid && oReady;
    sof_acc = acc && iSof;
    size_ok = iWidth >= XW'(3) && iWidth <= XW'(MAX_W) &&
              iHeight >= YW'(3) && iHeight <= YW'(MAX_H);
    wx = sof_acc ? '0 : x_q;
    ri = (x_q < XW'(MAX_W)) ? x_q : '0;
    ncol[0] = lb_b_q[ri];
    ncol[1] = lb_a_q[ri];
    ncol[2] = iPixel;

    st_d = st_q;
    w_d = w_q;
    h_d = h_q;
    mode_d = mode_q;
    cfg_d = cfg_q;
    x_d = x_q;
    y_d = y_q;
    wr = 1'b0;
    shift = 1'b0;
    emit = 1'b0;
    eol_n = 1'b0;
    cx = '0;
    cy = '0;
    rv = 1'b1;
    bv = 1'b1;

    if (sof_acc) begin
      w_d = iWidth;
      h_d = iHeight;
      mode_d = iBorder;
      cfg_d = !size_ok;
      st_d = S_IDLE;
      if (size_ok) begin
        st_d = S_FILL;
        x_d = XW'(1);
        y_d = '0;
        wr = 1'b1;
        shift = 1'b1;
      end
    end else begin
      unique case (1'b1)
        (st_q == S_FILL || st_q == S_RUN): begin
          if (acc) begin
            wr = 1'b1;
            shift = 1'b1;
            if (st_q == S_RUN && x_q != '0) begin
              emit = 1'b1;
              cx = x_q - XW'(1);
              cy = y_q - YW'(1);
            end
            if (x_q == w_q - XW'(1)) begin
              x_d = '0;
              y_d = y_q + YW'(1);
              st_d = (st_q == S_FILL) ? S_RUN : S_EOL;
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
        (st_q == S_EOL): begin
          if (free) begin
            emit = 1'b1;
            eol_n = 1'b1;
            rv = 1'b0;
            cx = w_q - XW'(1);
            cy = y_q - YW'(2);
            st_d = S_RUN;
            if (y_q == h_q) begin
              st_d = S_LAST;
              x_d = '0;
            end
          end
        end
        (st_q == S_LAST): begin
          // bottom row replays buffered lines; one extra step for x=W-1
          if (free) begin
            bv = 1'b0;
            cy = h_q - YW'(1);
            if (x_q < w_q) begin
              shift = 1'b1;
              x_d = x_q + XW'(1);
              emit = (x_q != '0);
              cx = x_q - XW'(1);
            end else begin
              emit = 1'b1;
              eol_n = 1'b1;
              rv = 1'b0;
              cx = w_q - XW'(1);
              st_d = S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end

    tv = (cy != '0);
    lv = (cx != '0);

    raw[0] = c2_q;
    raw[1] = c1_q;
    raw[2] = ncol;
    for (int c = 0; c < 3; c++) begin
      fr[c][1] = raw[c][1];
      fr[c][0] = tv ? raw[c][0] : (mode_q ? raw[c][1] : '0);
      fr[c][2] = bv ? raw[c][2] : (mode_q ? raw[c][1] : '0);
    end
    fc[1] = fr[1];
    fc[0] = lv ? fr[0] : (mode_q ? fr[1] : '0);
    fc[2] = rv ? fr[2] : (mode_q ? fr[1] : '0);
    win_n = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win_n[(r*3+c)*PIX_W +: PIX_W] = fc[c][r];

    c1_d = shift ? ncol : c1_q;
    c2_d = shift ? c1_q : c2_q;

    val_d = val_q;
    win_d = win_q;
    sof_d = sof_q;
    eol_d = eol_q;
    if (free) begin
      val_d = emit;
      if (emit) begin
        win_d = win_n;
        sof_d = (cx == '0) && (cy == '0);
        eol_d = eol_n;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      st_q <= S_IDLE;
      w_q <= '0;
      h_q <= '0;
      x_q <= '0;
      y_q <= '0;
      mode_q <= 1'b0;
      cfg_q <= 1'b0;
      run_q <= 1'b0;
      val_q <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      win_q <= '0;
      c1_q <= '0;
      c2_q <= '0;
    end else begin
      st_q <= st_d;
      w_q <= w_d;
      h_q <= h_d;
      x_q <= x_d;
      y_q <= y_d;
      mode_q <= mode_d;
      cfg_q <= cfg_d;
      run_q <= 1'b1;
      val_q <= val_d;
      sof_q <= sof_d;
      eol_q <= eol_d;
      win_q <= win_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (wr) begin
      lb_a_q[wx] <= iPixel;
      lb_b_q[wx] <= lb_a_q[wx];
    end
  end

  assign oValid  = val_q;
  assign oWin    = win_q;
  assign oSof    = sof_q;
  assign oEol    = eol_q;
  assign oCfgErr = cfg_q;

endmodule

// File: tb/tb_window3x3_stream.sv
// Bench for window3x3_stream: fixed-frame vector table plus
// randomized frames checked against a coordinate-level window model.
module tb_window3x3_stream;
  localparam int PIX_W = 24;
  localparam int XW = 9;
  localparam int YW = 9;
  localparam int WW = 9 * PIX_W;

  logic iClk = 0, iRst = 0;
  logic [XW-1:0] iWidth = '0;
  logic [YW-1:0] iHeight = '0;
  logic iBorder = 0, iValid = 0, iSof = 0, iReady = 1;
  logic [PIX_W-1:0] iPixel = '0;
  logic oReady, oValid, oSof, oEol, oCfgErr;
  logic [WW-1:0] oWin;

  window3x3_stream dut (
    .iClk(iClk), .iRst(iRst), .iWidth(iWidth), .iHeight(iHeight),
    .iBorder(iBorder), .iValid(iValid), .iSof(iSof), .iPixel(iPixel),
    .oReady(oReady), .oValid(oValid), .iReady(iReady), .oWin(oWin),
    .oSof(oSof), .oEol(oEol), .oCfgErr(oCfgErr)
  );

  always #5 iClk = ~iClk;

  int errors = 0, checks = 0;
  bit act = 0, rnd_rdy = 0;
  int mw = 4, mh = 3, mm = 0, idx = 0, vseen = 0;
  logic [PIX_W-1:0] mfr [0:4095];
  logic [WW-1:0] cap [0:15];

  typedef struct {
    int mode; int y; int x;
    logic [7:0] s [9];
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string nm, input logic [WW-1:0] got,
                     input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_win(int y, int x);
    logic [WW-1:0] r = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int yy = y + dy, xx = x + dx;
        logic [PIX_W-1:0] p = '0;
        if (mm != 0) begin
          yy = (yy < 0) ? 0 : (yy >= mh) ? mh - 1 : yy;
          xx = (xx < 0) ? 0 : (xx >= mw) ? mw - 1 : xx;
          p = mfr[yy*mw+xx];
        end else if (yy >= 0 && yy < mh && xx >= 0 && xx < mw) begin
          p = mfr[yy*mw+xx];
        end
        r[((dy+1)*3+dx+1)*PIX_W +: PIX_W] = p;
      end
    return r;
  endfunction

  initial forever begin
    @(posedge iClk);
    #1 iReady = rnd_rdy ? ($urandom_range(1) == 1) : 1'b1;
  end

  initial begin : mon
    bit hold = 0;
    logic [WW-1:0] hw;
    logic [1:0] hf;
    forever begin
      @(negedge iClk);
      if (!iRst) begin
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_valid", oValid, 1'b1);
          chk("hold_win", oWin, hw);
          chk("hold_flags", {oSof, oEol}, hf);
        end
        if (oValid) vseen++;
        if (oValid && iReady) begin
          if (!act) begin
            chk("stray_window", oValid, 1'b0);
          end else begin
            int y, x;
            y = idx / mw;
            x = idx % mw;
            chk($sformatf("win(%0d,%0d)", y, x), oWin, exp_win(y, x));
            chk("sof", oSof, (y == 0 && x == 0));
            chk("eol", oEol, (x == mw - 1));
            if (idx < 16) cap[idx] = oWin;
            idx++;
            if (idx == mw * mh) act = 0;
          end
        end
        hold = oValid && !iReady;
        hw = oWin;
        hf = {oSof, oEol};
      end
    end
  end

  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic push(input logic [PIX_W-1:0] p, input bit sof,
                      output bit ok);
    int n = 0;
    bit a;
    iValid = 1;
    iSof = sof;
    iPixel = p;
    do begin
      @(negedge iClk);
      a = oReady;
      cyc();
      n++;
    end while (!a && n < 5000);
    iValid = 0;
    iSof = 0;
    ok = a;
    if (!a) chk("push_timeout", a, 1'b1);
  endtask

  task automatic run_frame(input int w, input int h, input int mode,
                           input int kind, input int vpct,
                           input int stop_at);
    bit ok;
    int n;
    for (int k = 0; k < w * h; k++) begin
      int y = k / w, x = k % w;
      logic [PIX_W-1:0] p;
      logic [7:0] b;
      if (stop_at >= 0 && k == stop_at) return;
      b = 8'(y * 16 + x);
      p = kind != 0 ? PIX_W'($urandom) : {3{b}};
      while ($urandom_range(99) >= vpct) cyc();
      if (k == 0) begin
        iWidth = XW'(w);
        iHeight = YW'(h);
        iBorder = mode[0];
      end
      push(p, k == 0, ok);
      if (!ok) return;
      if (k == 0) begin
        act = 1; mw = w; mh = h; mm = mode; idx = 0;
      end
      mfr[k] = p;
    end
    n = 0;
    while (act && n < 10 * w * h + 200) begin
      cyc();
      n++;
    end
    chk("frame_count", idx, w * h);
    repeat (4) cyc();
  endtask

  task automatic run_table(input int mode);
    for (int i = 0; i < 6; i++) begin
      if (vt[i].mode == mode) begin
        logic [WW-1:0] e;
        for (int s = 0; s < 9; s++)
          e[s*PIX_W +: PIX_W] = {3{vt[i].s[s]}};
        chk($sformatf("tbl m%0d (%0d,%0d)", mode, vt[i].y, vt[i].x),
            cap[vt[i].y*4+vt[i].x], e);
      end
    end
  endtask

  task automatic bad_cfg(input int w, input int h);
    bit ok;
    int v0;
    iWidth = XW'(w);
    iHeight = YW'(h);
    iBorder = 0;
    push(24'h0a0b0c, 1, ok);
    act = 0;
    v0 = vseen;
    for (int k = 0; k < 5; k++) push(PIX_W'($urandom), 0, ok);
    repeat (5) cyc();
    chk($sformatf("cfgerr_set w%0d h%0d", w, h), oCfgErr, 1'b1);
    chk("cfg_no_valid", vseen, v0);
  endtask

  initial begin
    vt[0].mode = 0; vt[0].y = 0; vt[0].x = 0;
    vt[0].s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h00, 8'h10, 8'h11};
    vt[1].mode = 0; vt[1].y = 1; vt[1].x = 1;
    vt[1].s = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12,
                8'h20, 8'h21, 8'h22};
    vt[2].mode = 0; vt[2].y = 2; vt[2].x = 3;
    vt[2].s = '{8'h12, 8'h13, 8'h00, 8'h22, 8'h23, 8'h00,
                8'h00, 8'h00, 8'h00};
    vt[3].mode = 1; vt[3].y = 0; vt[3].x = 0;
    vt[3].s = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01,
                8'h10, 8'h10, 8'h11};
    vt[4].mode = 1; vt[4].y = 2; vt[4].x = 3;
    vt[4].s = '{8'h12, 8'h13, 8'h13, 8'h22, 8'h23, 8'h23,
                8'h22, 8'h23, 8'h23};
    vt[5].mode = 1; vt[5].y = 1; vt[5].x = 1;
    vt[5].s = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12,
                8'h20, 8'h21, 8'h22};

    #12;
    chk("rst_valid", oValid, 1'b0);
    chk("rst_ready", oReady, 1'b0);
    chk("rst_flags", {oSof, oEol, oCfgErr}, 3'b000);
    chk("rst_win", oWin, '0);
    iRst = 1;
    repeat (2) cyc();

    run_frame(4, 3, 0, 0, 100, -1);
    run_table(0);
    run_frame(4, 3, 1, 0, 100, -1);
    run_table(1);

    bad_cfg(2, 3);
    run_frame(4, 3, 0, 1, 100, -1);
    chk("cfgerr_clr", oCfgErr, 1'b0);
    bad_cfg(481, 5);
    bad_cfg(4, 273);
    run_frame(4, 3, 1, 1, 80, -1);
    chk("cfgerr_clr2", oCfgErr, 1'b0);

    run_frame(4, 3, 0, 1, 100, 6);
    run_frame(4, 3, 1, 1, 70, -1);

    run_frame(4, 3, 0, 1, 100, 7);
    #2 iRst = 0;
    act = 0;
    #1;
    chk("midrst_valid", oValid, 1'b0);
    chk("midrst_ready", oReady, 1'b0);
    repeat (3) cyc();
    iRst = 1;
    repeat (2) cyc();
    run_frame(4, 3, 1, 1, 100, -1);

    rnd_rdy = 1;
    run_frame(37, 19, int'($urandom_range(1)), 1, 70, -1);
    run_frame(3, 3, 0, 1, 70, -1);
    run_frame(3, 3, 1, 1, 70, -1);
    run_frame(480, 4, 1, 1, 70, -1);
    run_frame(480, 3, 0, 1, 70, -1);
    run_frame(3, 272, 1, 1, 70, -1);
    run_frame(9, 7, 0, 1, 70, 20);
    run_frame(11, 6, 1, 1, 70, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
